imem_loader: RTL and testbench

- Write-side companion to the byte-addressed instruction ROM.
- Accepts a framed byte stream over a valid/ready interface and writes the payload byte-by-byte into the instruction memory byte array, little-endian order preserved.
- Holds the CPU off while loading.
- Frame format:
  - 4-byte length header, little endian.
  - LEN payload bytes.
  - 1 trailer byte: 8-bit additive checksum of the payload.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader_le_byte_assembler.sv | 40 ++++
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state encoding, header size and counter-width helper.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES      = 4;
    localparam int ADDR_WIDTH_DEF = 12;
    localparam int CNT_WIDTH      = ADDR_WIDTH_DEF + 1;

    // One extra bit so a full-memory length still fits in the counter.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in / memory byte-write out bundle of the loader.
// The loader is the slave side; a host or bench drives the master side.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int BYTE_WIDTH = 8
);

    logic                  in_valid;
    logic [BYTE_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [BYTE_WIDTH-1:0] wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/imem_loader_le_byte_assembler.sv
// Little-endian word assembler: byte k of a sequence lands in bits [8k+7:8k].
// word_next exposes the word with the current byte inserted, so a caller can act on the final byte in the same cycle.
module le_byte_assembler #(
    parameter int BYTE_WIDTH = 8,
    parameter int NUM_BYTES  = 4,
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1,
    localparam int WORD_W    = NUM_BYTES * BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    output logic [WORD_W-1:0]     word,
    output logic [WORD_W-1:0]     word_next,
    output logic [IDX_W-1:0]      idx,
    output logic                  last
);

    always_comb begin
        word_next = word;
        word_next[idx*BYTE_WIDTH +: BYTE_WIDTH] = byte_in;
    end

    assign last = (idx == IDX_W'(NUM_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            idx  <= '0;
        end else if (clear) begin
            word <= '0;
            idx  <= '0;
        end else if (load) begin
            word <= word_next;
            idx  <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: header LEN, LEN payload bytes, additive checksum trailer.
// Payload bytes are written one cycle after acceptance to consecutive memory addresses from 0.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int BYTE_WIDTH = 8,
    parameter int MEM_BYTES  = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    imem_loader_if.slave          bus,
    output logic                  busy,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [BYTE_WIDTH-1:0] checksum
);

    localparam int CNT_W = cnt_width(ADDR_WIDTH);
    localparam int LEN_W = HDR_BYTES * BYTE_WIDTH;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic                    accept;
    logic [LEN_W-1:0]        len_word;
    logic [LEN_W-1:0]        len_next;
    logic [$clog2(HDR_BYTES)-1:0] hdr_idx;
    logic                    hdr_last;
    logic                    last_payload;
    logic                    oversize;

    logic                    vld_p1;
    logic [ADDR_WIDTH-1:0]   wr_addr_p1;
    logic [BYTE_WIDTH-1:0]   wr_data_p1;

    assign bus.in_ready = (state == HDR) || (state == LOAD) || (state == CHK);
    assign accept       = bus.in_valid && bus.in_ready;

    le_byte_assembler #(
        .BYTE_WIDTH (BYTE_WIDTH),
        .NUM_BYTES  (HDR_BYTES)
    ) u_len_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     ((state == IDLE) && start),
        .load      (accept && (state == HDR)),
        .byte_in   (bus.in_data),
        .word      (len_word),
        .word_next (len_next),
        .idx       (hdr_idx),
        .last      (hdr_last)
    );

    assign cnt_next     = cnt + CNT_W'(1);
    assign last_payload = (LEN_W'(cnt_next) == len_word);
    assign oversize     = (len_next > LEN_W'(MEM_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            checksum   <= '0;
            vld_p1     <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            vld_p1 <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= HDR;
                        busy     <= 1'b1;
                        error    <= 1'b0;
                        checksum <= '0;
                        cnt      <= '0;
                    end
                end
                HDR: begin
                    if (accept && hdr_last) begin
                        if (oversize) begin
                            state <= ERR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else if (len_next == '0) begin
                            state <= CHK;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                // write stage p1: byte accepted here appears on the memory port next cycle
                LOAD: begin
                    if (accept) begin
                        vld_p1     <= 1'b1;
                        wr_addr_p1 <= cnt[ADDR_WIDTH-1:0];
                        wr_data_p1 <= bus.in_data;
                        cnt        <= cnt_next;
                        checksum   <= checksum + bus.in_data;
                        if (last_payload) begin
                            state <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (accept) begin
                        if (bus.in_data == checksum) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_en   = vld_p1;
    assign bus.wr_addr = wr_addr_p1;
    assign bus.wr_data = wr_data_p1;
    assign cpu_hold    = busy;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: frames are built from a byte-list model,
// expected memory writes are queued by the driver and retired by an independent monitor.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       cpu_hold;
    logic       done;
    logic       error;
    logic [7:0] checksum;

    imem_loader_if #(.ADDR_WIDTH(12), .BYTE_WIDTH(8)) bus ();

    imem_loader #(
        .ADDR_WIDTH (12),
        .BYTE_WIDTH (8),
        .MEM_BYTES  (4096)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    int          errors = 0;
    int          checks = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    bit          prev_done = 1'b0;
    logic [11:0] last_addr = '0;
    wr_t         exp_q[$];
    logic [7:0]  pl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: retires expected writes and watches done/cpu_hold.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cpu_hold_eq_busy", cpu_hold, busy);
            if (bus.wr_en) begin
                wr_t e;
                wr_cnt++;
                last_addr = bus.wr_addr;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", bus.wr_addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", bus.wr_addr, e.addr);
                    chk("write_data", bus.wr_data, e.data);
                end
            end
            if (done) begin
                done_cnt++;
                if (prev_done) chk("done_single_cycle", 1, 0);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_error_clear", error, 0);
        chk("start_checksum_clear", checksum, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit is_pl,
                             input int addr, input bit st);
        bit acc = 1'b0;
        int guard = 0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                start = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = b;
                start = st;
                acc = bus.in_ready;
                if (acc) begin
                    if (is_pl) exp_q.push_back({addr[11:0], b});
                    chk("hold_on_accept", cpu_hold, 1);
                end
            end
            guard++;
            @(posedge clk);
        end
        if (!acc) chk("byte_accept_timeout", 0, 1);
    endtask

    task automatic run_frame(input logic [31:0] len_f, input logic [7:0] trailer,
                             input bit gaps, input bit poke);
        logic [7:0] sum = 8'h00;
        bit ok = (len_f <= 32'd4096);
        bit exp_done;
        bit ended = 1'b0;
        if (ok) foreach (pl[i]) sum += pl[i];
        else sum = 8'h00;
        exp_done = ok && (trailer == sum);
        wr_cnt = 0;
        done_cnt = 0;
        do_start();
        for (int k = 0; k < 4; k++) send_byte(len_f[8*k +: 8], gaps, 1'b0, 0, 1'b0);
        if (ok) begin
            for (int i = 0; i < pl.size(); i++) send_byte(pl[i], gaps, 1'b1, i, poke && (i == 1));
            send_byte(trailer, gaps, 1'b0, 0, 1'b0);
        end
        for (int c = 0; c < 20 && !ended; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            start = 1'b0;
            if (!busy) ended = 1'b1;
        end
        chk("frame_end_busy_drop", ended, 1);
        repeat (2) @(negedge clk);
        chk("done_pulses", done_cnt, exp_done);
        chk("error_flag", error, !exp_done);
        chk("checksum_final", checksum, ok ? 32'(sum) : 32'd0);
        chk("write_count", wr_cnt, ok ? pl.size() : 0);
        chk("pending_writes", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_wr_en"}, bus.wr_en, 0);
        chk({tag, "_wr_addr"}, bus.wr_addr, 0);
        chk({tag, "_wr_data"}, bus.wr_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_checksum"}, checksum, 0);
    endtask

    initial begin
        logic [7:0] s;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Basic load and bad checksum.
        pl = '{8'h13, 8'h05, 8'h10, 8'h00};
        run_frame(32'd4, 8'h28, 1'b0, 1'b0);
        chk("basic_checksum_0x28", checksum, 8'h28);
        run_frame(32'd4, 8'h29, 1'b0, 1'b0);

        // Oversize header, then zero length (also clears the sticky error).
        pl.delete();
        run_frame(32'd4097, 8'h00, 1'b0, 1'b0);
        run_frame(32'd0, 8'h00, 1'b0, 1'b0);

        // Random short frames with random gaps and random trailer validity.
        for (int f = 0; f < 6; f++) begin
            int n = $urandom_range(1, 40);
            pl.delete();
            s = 8'h00;
            for (int i = 0; i < n; i++) begin
                pl.push_back(8'($urandom));
                s += pl[i];
            end
            if ($urandom_range(0, 1) == 0) s = s + 8'($urandom_range(1, 255));
            run_frame(32'(n), s, 1'b1, 1'b0);
        end

        // Full memory with random bubbles.
        pl.delete();
        s = 8'h00;
        for (int i = 0; i < 4096; i++) begin
            pl.push_back(8'($urandom));
            s += pl[i];
        end
        run_frame(32'd4096, s, 1'b1, 1'b0);
        chk("full_last_wr_addr", last_addr, 12'hFFF);

        // Reset in the middle of LOAD after two payload bytes.
        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
        done_cnt = 0;
        do_start();
        for (int k = 0; k < 4; k++) send_byte((k == 0) ? 8'd8 : 8'd0, 1'b0, 1'b0, 0, 1'b0);
        send_byte(pl[0], 1'b0, 1'b1, 0, 1'b0);
        send_byte(pl[1], 1'b0, 1'b1, 1, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        chk("midreset_pending_writes", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_no_done", done_cnt, 0);

        // Fresh frame after reset, with a stray start pulse while busy.
        pl.delete();
        s = 8'h00;
        for (int i = 0; i < 12; i++) begin
            pl.push_back(8'($urandom));
            s += pl[i];
        end
        run_frame(32'd12, s, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
